// File: rtl/mac_pkg.sv
// Shared constants and scheduler state encoding for the MAC transmit path.
package mac_pkg;

    localparam int unsigned DefAddrWidth = 11;
    localparam int unsigned DefIfgCycles = 12;
    localparam int unsigned DefTimeout   = 4096;

    typedef enum logic [5:0] {
        StIdle      = 6'b000001,
        StLoad      = 6'b000010,
        StTrig      = 6'b000100,
        StWaitStart = 6'b001000,
        StWaitEnd   = 6'b010000,
        StIfg       = 6'b100000
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after `last`, wrapping around.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic            en,
    input  logic [IdxW-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx,
    output logic            any
);

    logic [IdxW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = last;
        for (int i = 0; i < int'(N); i++) begin
            pos = (pos == IdxW'(N - 1)) ? '0 : pos + IdxW'(1);
            if (en && !any && req[pos]) begin
                any      = 1'b1;
                idx      = pos;
                gnt[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_tx_sched.sv
// Shares one MAC transmitter between N_REQ frame sources: round-robin grant, trigger,
// track txen, enforce inter-frame gap and report done or timeout.
module mac_tx_sched
    import mac_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned IFG_CYCLES = DefIfgCycles,
    parameter int unsigned TIMEOUT    = DefTimeout,
    localparam int unsigned IdxW      = $clog2(N_REQ)
) (
    input  logic                        i_gclk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_st,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_ed,
    output logic [N_REQ-1:0]            o_req_ack,
    output logic [N_REQ-1:0]            o_req_done,
    output logic                        o_tx_err,
    output logic [ADDR_WIDTH-1:0]       o_data_st,
    output logic [ADDR_WIDTH-1:0]       o_data_ed,
    output logic                        o_tx_trig,
    input  logic                        i_eth_txen,
    output logic                        o_busy,
    output logic [IdxW-1:0]             o_grant_id
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
    localparam logic [15:0] IfgLast     = 16'(IFG_CYCLES - 1);

    sched_state_e     state_q;
    logic [IdxW-1:0]  last_q;
    logic [15:0]      cnt_q;

    logic [N_REQ-1:0] arb_gnt;
    logic [IdxW-1:0]  arb_idx;
    logic             arb_any;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req  (i_req_valid),
        .en   (state_q == StIdle),
        .last (last_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    always_ff @(posedge i_gclk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            last_q     <= IdxW'(N_REQ - 1);
            cnt_q      <= '0;
            o_req_ack  <= '0;
            o_req_done <= '0;
            o_tx_err   <= 1'b0;
            o_data_st  <= '0;
            o_data_ed  <= '0;
            o_tx_trig  <= 1'b0;
            o_busy     <= 1'b0;
            o_grant_id <= '0;
        end else begin
            o_req_ack  <= '0;
            o_req_done <= '0;
            o_tx_err   <= 1'b0;
            o_tx_trig  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        o_data_st  <= i_req_st[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        o_data_ed  <= i_req_ed[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        o_grant_id <= arb_idx;
                        last_q     <= arb_idx;
                        o_req_ack  <= arb_gnt;
                        o_busy     <= 1'b1;
                        state_q    <= StLoad;
                    end
                end
                StLoad: begin
                    // LOAD is always low on trig, so the MAC sees a clean rising edge.
                    o_tx_trig <= 1'b1;
                    state_q   <= StTrig;
                end
                StTrig: begin
                    cnt_q   <= '0;
                    state_q <= StWaitStart;
                end
                StWaitStart: begin
                    if (i_eth_txen) begin
                        cnt_q   <= '0;
                        state_q <= StWaitEnd;
                    end else if (cnt_q == TimeoutLast) begin
                        o_tx_err <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= StIfg;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StWaitEnd: begin
                    if (!i_eth_txen) begin
                        o_req_done <= N_REQ'(1) << o_grant_id;
                        cnt_q      <= '0;
                        state_q    <= StIfg;
                    end else if (cnt_q == TimeoutLast) begin
                        o_tx_err <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= StIfg;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StIfg: begin
                    if (cnt_q == IfgLast) begin
                        cnt_q   <= '0;
                        o_busy  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_sched.sv
// Directed self-checking bench for mac_tx_sched with a hand-driven MAC txen.
module tb_mac_tx_sched;

    localparam int AW = 11;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   valid;
    logic [NR*AW-1:0] req_st;
    logic [NR*AW-1:0] req_ed;
    logic [NR-1:0]   ack;
    logic [NR-1:0]   done;
    logic            tx_err;
    logic [AW-1:0]   data_st;
    logic [AW-1:0]   data_ed;
    logic            tx_trig;
    logic            txen;
    logic            busy;
    logic [1:0]      grant_id;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    mac_tx_sched dut (
        .i_gclk      (clk),
        .i_rst       (rst),
        .i_req_valid (valid),
        .i_req_st    (req_st),
        .i_req_ed    (req_ed),
        .o_req_ack   (ack),
        .o_req_done  (done),
        .o_tx_err    (tx_err),
        .o_data_st   (data_st),
        .o_data_ed   (data_ed),
        .o_tx_trig   (tx_trig),
        .i_eth_txen  (txen),
        .o_busy      (busy),
        .o_grant_id  (grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        valid = '0;
        txen = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        valid = '0;
        txen = 1'b0;
        req_st = '0;
        req_ed = '0;
        tick;
        n_total++;
        if ({ack, done, tx_err, tx_trig, busy, grant_id} !== '0)
            $display("FAIL reset_ctrl: got %b want 0", {ack, done, tx_err, tx_trig, busy, grant_id});
        else n_pass++;
        n_total++;
        if ({data_st, data_ed} !== '0)
            $display("FAIL reset_addr: got %h want 0", {data_st, data_ed});
        else n_pass++;
        rst = 1'b0;
        // stray txen in IDLE must not start anything
        txen = 1'b1;
        repeat (3) tick;
        n_total++;
        if (busy !== 1'b0 || tx_trig !== 1'b0)
            $display("FAIL stray_txen_idle: busy=%b trig=%b want 0 0", busy, tx_trig);
        else n_pass++;
        txen = 1'b0;
        tick;
    endtask

    task automatic test_single;
        do_reset;
        req_st[2*AW +: AW] = 11'h010;
        req_ed[2*AW +: AW] = 11'h04F;
        valid = 4'b0100;
        tick;
        n_total++;
        if (ack !== 4'b0100) $display("FAIL single_ack: got %b want 0100", ack);
        else n_pass++;
        n_total++;
        if (data_st !== 11'h010 || data_ed !== 11'h04F)
            $display("FAIL single_addr: got %h/%h want 010/04f", data_st, data_ed);
        else n_pass++;
        n_total++;
        if (grant_id !== 2'd2 || tx_trig !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_load: id=%0d trig=%b busy=%b want 2 0 1", grant_id, tx_trig, busy);
        else n_pass++;
        valid = '0;
        tick;
        n_total++;
        if (tx_trig !== 1'b1 || ack !== 4'b0000)
            $display("FAIL single_trig: trig=%b ack=%b want 1 0000", tx_trig, ack);
        else n_pass++;
        tick;
        n_total++;
        if (tx_trig !== 1'b0) $display("FAIL single_trig_pulse: got %b want 0", tx_trig);
        else n_pass++;
        txen = 1'b1;
        repeat (70) tick;
        txen = 1'b0;
        n_total++;
        if (done !== 4'b0000) $display("FAIL single_done_early: got %b want 0000", done);
        else n_pass++;
        tick;
        n_total++;
        if (done !== 4'b0100) $display("FAIL single_done: got %b want 0100", done);
        else n_pass++;
        repeat (11) tick;
        n_total++;
        if (busy !== 1'b1) $display("FAIL single_ifg_busy: got %b want 1", busy);
        else n_pass++;
        tick;
        n_total++;
        if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_round_robin;
        int c;
        int t_done;
        logic [3:0] exp_oh;
        logic [AW-1:0] exp_st;
        do_reset;
        for (int k = 0; k < NR; k++) begin
            req_st[k*AW +: AW] = 11'(12'h100 + 16 * k);
            req_ed[k*AW +: AW] = 11'(12'h300 + 16 * k);
        end
        valid = 4'hF;
        t_done = 0;
        for (int g = 0; g < 5; g++) begin
            exp_oh = 4'b0001 << (g % 4);
            exp_st = 11'(12'h100 + 16 * (g % 4));
            c = 0;
            while (ack == '0 && c < 200) begin tick; c++; end
            n_total++;
            if (ack !== exp_oh || data_st !== exp_st)
                $display("FAIL rr_grant%0d: ack=%b st=%h want %b %h", g, ack, data_st, exp_oh, exp_st);
            else n_pass++;
            if (g > 0) begin
                n_total++;
                if (cyc - t_done !== 13)
                    $display("FAIL rr_spacing%0d: got %0d want 13", g, cyc - t_done);
                else n_pass++;
            end
            c = 0;
            while (tx_trig !== 1'b1 && c < 50) begin tick; c++; end
            tick;
            txen = 1'b1;
            repeat (5) tick;
            txen = 1'b0;
            c = 0;
            while (done == '0 && c < 50) begin tick; c++; end
            t_done = cyc;
            n_total++;
            if (done !== exp_oh) $display("FAIL rr_done%0d: got %b want %b", g, done, exp_oh);
            else n_pass++;
        end
        valid = '0;
    endtask

    task automatic test_start_timeout;
        int c;
        int t_ws;
        int n_done;
        do_reset;
        req_st[1*AW +: AW] = 11'h020;
        valid = 4'b0010;
        c = 0;
        while (ack == '0 && c < 20) begin tick; c++; end
        valid = '0;
        c = 0;
        while (tx_trig !== 1'b1 && c < 20) begin tick; c++; end
        tick;
        t_ws = cyc;
        n_done = 0;
        c = 0;
        while (tx_err !== 1'b1 && c < 5000) begin
            tick;
            c++;
            if (done != '0) n_done++;
        end
        n_total++;
        if (tx_err !== 1'b1 || cyc - t_ws !== 4096)
            $display("FAIL st_timeout: err=%b after %0d want 1 after 4096", tx_err, cyc - t_ws);
        else n_pass++;
        n_total++;
        if (grant_id !== 2'd1 || n_done !== 0)
            $display("FAIL st_timeout_id: id=%0d dones=%0d want 1 0", grant_id, n_done);
        else n_pass++;
        valid = 4'b0001;
        t_ws = cyc;
        c = 0;
        while (ack == '0 && c < 100) begin tick; c++; end
        n_total++;
        if (ack !== 4'b0001 || cyc - t_ws !== 13)
            $display("FAIL st_timeout_next: ack=%b after %0d want 0001 after 13", ack, cyc - t_ws);
        else n_pass++;
        valid = '0;
    endtask

    task automatic test_end_timeout;
        int c;
        int t_we;
        int n_done;
        do_reset;
        valid = 4'b0001;
        c = 0;
        while (ack == '0 && c < 20) begin tick; c++; end
        valid = '0;
        c = 0;
        while (tx_trig !== 1'b1 && c < 20) begin tick; c++; end
        tick;
        txen = 1'b1;
        tick;
        t_we = cyc;
        n_done = 0;
        c = 0;
        while (tx_err !== 1'b1 && c < 5000) begin
            tick;
            c++;
            if (done != '0) n_done++;
        end
        n_total++;
        if (tx_err !== 1'b1 || cyc - t_we !== 4096)
            $display("FAIL end_timeout: err=%b after %0d want 1 after 4096", tx_err, cyc - t_we);
        else n_pass++;
        n_total++;
        if (grant_id !== 2'd0 || n_done !== 0)
            $display("FAIL end_timeout_id: id=%0d dones=%0d want 0 0", grant_id, n_done);
        else n_pass++;
        txen = 1'b0;
        repeat (12) tick;
        n_total++;
        if (busy !== 1'b0) $display("FAIL end_timeout_idle: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_late_request;
        int c;
        int t_done;
        int n_ack;
        do_reset;
        valid = 4'b0001;
        c = 0;
        while (ack == '0 && c < 20) begin tick; c++; end
        valid = '0;
        c = 0;
        while (tx_trig !== 1'b1 && c < 20) begin tick; c++; end
        tick;
        txen = 1'b1;
        tick;
        tick;
        valid = 4'b0010;
        repeat (3) tick;
        txen = 1'b0;
        c = 0;
        while (done == '0 && c < 20) begin tick; c++; end
        t_done = cyc;
        n_total++;
        if (done !== 4'b0001) $display("FAIL late_done0: got %b want 0001", done);
        else n_pass++;
        tick;
        tick;
        valid = 4'b1010;
        tick;
        valid = 4'b0010;
        c = 0;
        while (ack == '0 && c < 100) begin tick; c++; end
        n_total++;
        if (ack !== 4'b0010 || cyc - t_done !== 13)
            $display("FAIL late_grant1: ack=%b after %0d want 0010 after 13", ack, cyc - t_done);
        else n_pass++;
        valid = '0;
        c = 0;
        while (tx_trig !== 1'b1 && c < 20) begin tick; c++; end
        tick;
        txen = 1'b1;
        tick;
        tick;
        txen = 1'b0;
        c = 0;
        while (done == '0 && c < 20) begin tick; c++; end
        n_total++;
        if (done !== 4'b0010) $display("FAIL late_done1: got %b want 0010", done);
        else n_pass++;
        n_ack = 0;
        repeat (40) begin
            tick;
            if (ack != '0) n_ack++;
        end
        n_total++;
        if (n_ack !== 0) $display("FAIL withdrawn_acked: got %0d acks want 0", n_ack);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        int c;
        do_reset;
        req_st[0*AW +: AW] = 11'h0A5;
        req_st[2*AW +: AW] = 11'h1AB;
        req_ed[2*AW +: AW] = 11'h2CD;
        valid = 4'b0100;
        c = 0;
        while (ack == '0 && c < 20) begin tick; c++; end
        valid = '0;
        c = 0;
        while (tx_trig !== 1'b1 && c < 20) begin tick; c++; end
        tick;
        txen = 1'b1;
        tick;
        tick;
        n_total++;
        if (busy !== 1'b1 || data_st !== 11'h1AB)
            $display("FAIL midrst_pre: busy=%b st=%h want 1 1ab", busy, data_st);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({ack, done, tx_err, tx_trig, busy, grant_id, data_st, data_ed} !== '0)
            $display("FAIL midrst_outputs: got %h want 0",
                     {ack, done, tx_err, tx_trig, busy, grant_id, data_st, data_ed});
        else n_pass++;
        txen = 1'b0;
        valid = 4'b0101;
        tick;
        rst = 1'b0;
        tick;
        n_total++;
        if (ack !== 4'b0001 || grant_id !== 2'd0 || data_st !== 11'h0A5)
            $display("FAIL midrst_first: ack=%b id=%0d st=%h want 0001 0 0a5", ack, grant_id, data_st);
        else n_pass++;
        valid = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_start_timeout;
        test_end_timeout;
        test_late_request;
        test_reset_mid_frame;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/mac_tx_sched.md
# mac_tx_sched

Frame scheduler that shares the single Ethernet MAC transmitter between `N_REQ` frame sources, such as voice channels. Each source posts a frame descriptor: start and end addresses in the shared TX buffer. The scheduler grants one source at a time in round-robin order and loads that source's addresses into the MAC's `i_data_st`/`i_data_ed`. It then issues the rising-edge `tx_trig` and tracks the MAC's `o_eth_txen` to detect when the frame has finished. It enforces an inter-frame gap and reports completion or a timeout back to the granted source.

## Interface
- `ADDR_WIDTH`, 11, TX buffer address width; matches the MAC.
- `N_REQ`, 4, number of requesters; range 2..8.
- `IFG_CYCLES`, 12, idle cycles after each frame before the next grant; minimum 1.
- `TIMEOUT`, 4096, maximum cycles allowed in each wait state; counter is 16 bits.

Ports (one clock; reset is asynchronous and active-high):
- `i_gclk`  in  1  system clock; the MAC runs on the same clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  `N_REQ`  per-source "frame pending" level.
- `i_req_st`  in  `N_REQ*ADDR_WIDTH`  packed start addresses; source k occupies bits `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `i_req_ed`  in  `N_REQ*ADDR_WIDTH`  packed end addresses (inclusive), same packing.
- `o_req_ack`  out  `N_REQ`  one-hot, 1-cycle pulse: descriptor accepted; the source may drop valid.
- `o_req_done`  out  `N_REQ`  one-hot, 1-cycle pulse: frame transmitted.
- `o_tx_err`  out  1  1-cycle pulse: timeout; `o_grant_id` names the source.
- `o_data_st`  out  `ADDR_WIDTH`  connects to the MAC `i_data_st`.
- `o_data_ed`  out  `ADDR_WIDTH`  connects to the MAC `i_data_ed`.
- `o_tx_trig`  out  1  connects to the MAC `i_tx_trig`; a single-cycle high pulse.
- `i_eth_txen`  in  1  the MAC `o_eth_txen`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_grant_id`  out  `$clog2(N_REQ)`  index of the current or most recent grant.

## Operation
- All outputs are registered.
- Reset values: every output 0; state IDLE; round-robin pointer `last = N_REQ-1`, so source 0 wins first; counters 0.
- States: IDLE, LOAD, TRIG, WAIT_START, WAIT_END, IFG.
- IDLE
  - If any `i_req_valid` bit is set: pick the first set bit searching `last+1 .. last` with wrap-around.
  - Latch that source's start/end addresses into `o_data_st`/`o_data_ed`.
  - Set `o_grant_id`, update `last` to the granted index, pulse `o_req_ack[g]`, go to LOAD.
- LOAD: addresses are held stable for one cycle, then go to TRIG.
- TRIG: `o_tx_trig`=1 for exactly this cycle, then go to WAIT_START with the timeout counter cleared.
- WAIT_START
  - Sampling `i_eth_txen`=1 clears the counter and moves to WAIT_END.
  - A counter equal to `TIMEOUT-1` pulses `o_tx_err` and moves to IFG; `o_req_done` is not pulsed.
- WAIT_END
  - Sampling `i_eth_txen`=0 pulses `o_req_done[g]` and moves to IFG.
  - A timeout is handled exactly as in WAIT_START.
- IFG: count `IFG_CYCLES` cycles, then return to IDLE.
- `o_data_st`/`o_data_ed` hold their values until the next grant.
- Addresses are not validated. End < start is passed to the MAC unchanged, so the modulo-2^`ADDR_WIDTH` behaviour is the MAC's concern.

## Timing
- Grant latency:
  - cycle k: IDLE samples valid.
  - k+1: LOAD, ack pulse, addresses valid.
  - k+2: TRIG, `o_tx_trig`=1.
  - k+3: WAIT_START.
- `o_tx_trig` is always preceded by at least one low cycle, so the MAC's rising-edge detector sees every trigger.
- Completion: `o_req_done` is asserted the cycle after `i_eth_txen` is sampled low in WAIT_END, together with entry to IFG.
- Back-to-back frames: the minimum spacing from one done pulse to the next ack is `IFG_CYCLES+1` cycles.
- Valid edges outside IDLE are ignored; requests are only evaluated in IDLE.
  - A source that deasserts valid before IDLE is not granted.
  - A source that keeps valid after its ack is granted again on its next round-robin turn.
- A stray `i_eth_txen` in IDLE, LOAD or IFG is ignored.
- A `i_eth_txen` glitch high→low→high inside WAIT_END ends the frame at the first low.
- Asserting `i_rst` mid-frame returns everything to reset values immediately. `o_tx_trig` drops, and the MAC frame in flight is not tracked further.

## Structure
- Shared package `mac_pkg` holds:
  - the state enum (one-hot, 6 bits);
  - the default `ADDR_WIDTH`;
  - the `IFG_CYCLES` and `TIMEOUT` default constants shared with the MAC top.
- One sub-module, `rr_arbiter`:
  - parameter `N`;
  - inputs: request vector, enable, and `last` pointer;
  - outputs: one-hot grant, grant index, and any-request flag;
  - purely combinational;
  - the scheduler owns the pointer register.

## Test plan
- Single source: reset, then `valid[2]`=1 with start=0x010, end=0x04F. Expect ack[2] at k+1, `o_data_st`=0x010, `o_data_ed`=0x04F, and trig at k+2. After the model MAC holds txen high for 70 cycles, expect done[2] one cycle after txen falls.
- Round-robin: all four sources valid continuously. Grants are 0,1,2,3,0. Consecutive done→ack spacing is exactly 13 cycles.
- Start timeout: the MAC model never raises txen. Expect `o_tx_err` 4096 cycles after WAIT_START entry with `o_grant_id` correct, no done pulse, and the next grant after the IFG.
- End timeout: txen held high indefinitely. Expect `o_tx_err` after 4096 cycles in WAIT_END.
- Late request and withdrawal: `valid[1]` raised during WAIT_END of source 0 is granted after the IFG. `valid[3]` pulsed for one cycle during IFG is never acked.
- Reset mid-frame: assert `i_rst` in WAIT_END. All outputs go to 0 immediately; after release, source 0 is granted first.
